branch_predictor: RTL and testbench
===================================

// Module: branch_predictor
// PURPOSE
//  Fetch-stage control-flow predictor: direct-mapped BTB with 2-bit saturating
//  direction counters plus a return-address stack (RAS). Produces the
//  pred_taken/pc_pred pair that travels down the pipe to EX, where the branch
//  resolution logic compares it against the resolved outcome. Trained
//  non-speculatively from the EX resolution bus; one update per cycle.
// PARAMETERS
//  BTB_ENTRIES  64     BTB entries, power of 2, >=2; IDX_W = $clog2(BTB_ENTRIES)
//  RAS_DEPTH    8      RAS entries, power of 2, >=2
//  CNT_W        32     width of the wrapping performance counters
// PORTS
//  clk             in   1       clock
//  rst_n           in   1       async reset, active low
//  pc_f            in   32      fetch PC (word aligned)
//  pred_taken_f    out  1       predicted taken
//  pc_pred_f       out  32      predicted next PC
//  upd_valid       in   1       resolved control-flow instr in EX (cflow_valid)
//  upd_pc          in   32      PC of resolved instr
//  upd_mode        in   cflow_mode_t  CFLOW_BRANCH / CFLOW_JAL / CFLOW_JALR
//  upd_taken       in   1       resolved taken
//  upd_target      in   32      resolved target (pc_jump)
//  upd_is_call     in   1       JAL/JALR with rd in {x1,x5}
//  upd_is_ret      in   1       JALR with rs1 in {x1,x5}, rd not link
//  upd_mispredict  in   1       mispredict from EX
//  cnt_cflow       out  CNT_W   resolved cflow instr count
//  cnt_mispredict  out  CNT_W   mispredict count
// BEHAVIOUR
//  Entry: valid, tag = pc[31:IDX_W+2], target[31:0], type {BR,JMP,RET}, ctr[1:0].
//  Index = pc[IDX_W+1:2]; pc[1:0] ignored.
//  Lookup is combinational, same cycle: hit = valid && tag match.
//   taken = hit && (type!=BR || ctr[1]).
//   pc_pred_f = !taken ? pc_f+4 : (type==RET && ras_cnt!=0) ? ras_top : target.
//  Update at posedge clk when upd_valid:
//   hit: BR -> ctr +1 on taken / -1 on not-taken, saturating 0..3;
//        JMP/RET -> ctr=3; target <= upd_target when upd_taken.
//   miss & upd_taken: allocate/replace: valid=1, tag, target; ctr=2 for BR, 3 otherwise;
//        type = RET if upd_is_ret, BR if CFLOW_BRANCH, else JMP.
//   miss & !taken: no write.
//  Same-cycle lookup and update of same index: lookup sees pre-update contents.
//  RAS (circular buffer, ptr + count 0..RAS_DEPTH), on upd_valid only:
//   call only: push upd_pc+4; full -> overwrite oldest, count stays RAS_DEPTH.
//   ret only: pop; empty -> no change (count stays 0).
//   call & ret: replace top (pop then push); empty -> plain push.
//  Counters: cnt_cflow +1 per upd_valid; cnt_mispredict +1 per
//   upd_valid&&upd_mispredict; both wrap mod 2^CNT_W.
//  Reset (async, immediate): all valid bits, ctrs, RAS ptr/count, counters = 0;
//   hence pred_taken_f=0, pc_pred_f=pc_f+4 while in reset. Target/tag storage
//   need not reset. Reset mid-training discards all state.
//  No stall input: caller gates upd_valid; lookup is stateless.
// TESTING
//  1 after reset, pc_f=0x100 -> pred_taken_f=0, pc_pred_f=0x104; counters 0.
//  2 upd BR pc=0x100 taken tgt=0x80 -> next cycle pc_f=0x100: taken, 0x80;
//    then 2x not-taken updates (ctr 2->1->0) -> not taken, pc_pred_f=0x104.
//  3 aliasing (64 entries): BR taken at 0x100; lookup 0x200 (same index, diff tag)
//    -> miss, 0x204; taken update at 0x200 replaces it, 0x100 now misses.
//  4 call 0x1000 (push 0x1004); RET pc=0x2000 tgt=0x1004 allocates RET; call
//    0x3000 pushes 0x3004 -> lookup 0x2000 predicts 0x3004.
//  5 9 pushes (0x10..0x90 step 0x10), depth 8 -> 8 pops yield 0x90..0x20 in
//    order; 9th pop leaves count 0; RET lookup falls back to stored target.
//  6 drop rst_n between clock edges after training -> pred_taken_f=0 at once,
//    counters 0; release, 3 updates with 1 mispredict -> cnt_cflow=3, cnt_mispredict=1.

Source files
------------

// File: rtl/branch_predictor.sv
// Fetch-stage predictor: direct-mapped BTB with 2-bit direction counters and a
// circular return-address stack, trained from the EX resolution bus.
package branch_predictor_pkg;
   typedef enum logic [1:0] {
      CFLOW_BRANCH = 2'd0,
      CFLOW_JAL    = 2'd1,
      CFLOW_JALR   = 2'd2
   } cflow_mode_t;
endpackage

module branch_predictor
   import branch_predictor_pkg::*;
#(
   parameter int BTB_ENTRIES = 64,
   parameter int RAS_DEPTH   = 8,
   parameter int CNT_W       = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [31:0]      pc_f,
   output logic             pred_taken_f,
   output logic [31:0]      pc_pred_f,
   input  logic             upd_valid,
   input  logic [31:0]      upd_pc,
   input  cflow_mode_t      upd_mode,
   input  logic             upd_taken,
   input  logic [31:0]      upd_target,
   input  logic             upd_is_call,
   input  logic             upd_is_ret,
   input  logic             upd_mispredict,
   output logic [CNT_W-1:0] cnt_cflow,
   output logic [CNT_W-1:0] cnt_mispredict
);
   localparam int IDX_W = $clog2(BTB_ENTRIES);
   localparam int TAG_W = 32 - IDX_W - 2;
   localparam int RAS_W = $clog2(RAS_DEPTH);
   localparam logic [RAS_W:0] RAS_FULL = (RAS_W+1)'(RAS_DEPTH);
   localparam logic [1:0] TY_BR  = 2'd0;
   localparam logic [1:0] TY_JMP = 2'd1;
   localparam logic [1:0] TY_RET = 2'd2;

   logic             btb_valid_q  [BTB_ENTRIES];
   logic [1:0]       btb_ctr_q    [BTB_ENTRIES];
   logic [1:0]       btb_type_q   [BTB_ENTRIES];
   logic [TAG_W-1:0] btb_tag_q    [BTB_ENTRIES];
   logic [31:0]      btb_target_q [BTB_ENTRIES];
   logic [31:0]      ras_mem_q    [RAS_DEPTH];

   logic [RAS_W-1:0] ras_ptr_q, ras_ptr_d;
   logic [RAS_W:0]   ras_cnt_q, ras_cnt_d;
   logic [CNT_W-1:0] cnt_cflow_q, cnt_cflow_d;
   logic [CNT_W-1:0] cnt_mis_q, cnt_mis_d;

   logic [IDX_W-1:0] l_idx, u_idx;
   logic             l_hit, u_hit;
   logic [RAS_W-1:0] ras_top_idx;
   logic [31:0]      ras_top;

   logic             alloc, ctr_we, tgt_we;
   logic [1:0]       ctr_d, type_d;
   logic             ras_we;
   logic [RAS_W-1:0] ras_wr_idx;

   // Lookup: purely combinational on pre-update state
   assign l_idx       = pc_f[IDX_W+1:2];
   assign l_hit       = btb_valid_q[l_idx] && (btb_tag_q[l_idx] == pc_f[31:IDX_W+2]);
   assign ras_top_idx = ras_ptr_q - RAS_W'(1);
   assign ras_top     = ras_mem_q[ras_top_idx];

   always_comb begin
      pred_taken_f = l_hit && ((btb_type_q[l_idx] != TY_BR) || btb_ctr_q[l_idx][1]);
      pc_pred_f    = pc_f + 32'd4;
      if (pred_taken_f) begin
         if ((btb_type_q[l_idx] == TY_RET) && (ras_cnt_q != '0))
            pc_pred_f = ras_top;
         else
            pc_pred_f = btb_target_q[l_idx];
      end
   end

   assign u_idx = upd_pc[IDX_W+1:2];
   assign u_hit = btb_valid_q[u_idx] && (btb_tag_q[u_idx] == upd_pc[31:IDX_W+2]);

   always_comb begin
      alloc  = 1'b0;
      ctr_we = 1'b0;
      tgt_we = 1'b0;
      ctr_d  = btb_ctr_q[u_idx];
      type_d = TY_JMP;
      if (upd_valid) begin
         if (u_hit) begin
            ctr_we = 1'b1;
            tgt_we = upd_taken;
            if (btb_type_q[u_idx] == TY_BR) begin
               if (upd_taken)
                  ctr_d = (btb_ctr_q[u_idx] == 2'd3) ? 2'd3 : btb_ctr_q[u_idx] + 2'd1;
               else
                  ctr_d = (btb_ctr_q[u_idx] == 2'd0) ? 2'd0 : btb_ctr_q[u_idx] - 2'd1;
            end else begin
               ctr_d = 2'd3;
            end
         end else if (upd_taken) begin
            alloc  = 1'b1;
            ctr_we = 1'b1;
            tgt_we = 1'b1;
            if (upd_is_ret)
               type_d = TY_RET;
            else if (upd_mode == CFLOW_BRANCH)
               type_d = TY_BR;
            ctr_d = (type_d == TY_BR) ? 2'd2 : 2'd3;
         end
      end
   end

   // RAS: a call+ret pair on a non-empty stack rewrites the top in place
   always_comb begin
      ras_ptr_d  = ras_ptr_q;
      ras_cnt_d  = ras_cnt_q;
      ras_we     = 1'b0;
      ras_wr_idx = ras_ptr_q;
      if (upd_valid) begin
         if (upd_is_call && upd_is_ret && (ras_cnt_q != '0)) begin
            ras_we     = 1'b1;
            ras_wr_idx = ras_top_idx;
         end else if (upd_is_call) begin
            ras_we    = 1'b1;
            ras_ptr_d = ras_ptr_q + RAS_W'(1);
            ras_cnt_d = (ras_cnt_q == RAS_FULL) ? RAS_FULL : ras_cnt_q + (RAS_W+1)'(1);
         end else if (upd_is_ret && (ras_cnt_q != '0)) begin
            ras_ptr_d = ras_top_idx;
            ras_cnt_d = ras_cnt_q - (RAS_W+1)'(1);
         end
      end
   end

   always_comb begin
      cnt_cflow_d = cnt_cflow_q;
      cnt_mis_d   = cnt_mis_q;
      if (upd_valid) begin
         cnt_cflow_d = cnt_cflow_q + CNT_W'(1);
         if (upd_mispredict)
            cnt_mis_d = cnt_mis_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < BTB_ENTRIES; i++) begin
            btb_valid_q[i] <= 1'b0;
            btb_ctr_q[i]   <= 2'd0;
            btb_type_q[i]  <= TY_BR;
         end
         ras_ptr_q   <= '0;
         ras_cnt_q   <= '0;
         cnt_cflow_q <= '0;
         cnt_mis_q   <= '0;
      end else begin
         if (alloc) begin
            btb_valid_q[u_idx] <= 1'b1;
            btb_type_q[u_idx]  <= type_d;
         end
         if (ctr_we)
            btb_ctr_q[u_idx] <= ctr_d;
         ras_ptr_q   <= ras_ptr_d;
         ras_cnt_q   <= ras_cnt_d;
         cnt_cflow_q <= cnt_cflow_d;
         cnt_mis_q   <= cnt_mis_d;
      end
   end

   // Payload storage is qualified by the valid bits, so it carries no reset
   always_ff @(posedge clk) begin
      if (alloc)
         btb_tag_q[u_idx] <= upd_pc[31:IDX_W+2];
      if (tgt_we)
         btb_target_q[u_idx] <= upd_target;
      if (ras_we)
         ras_mem_q[ras_wr_idx] <= upd_pc + 32'd4;
   end

   assign cnt_cflow      = cnt_cflow_q;
   assign cnt_mispredict = cnt_mis_q;

endmodule

// File: tb/tb_branch_predictor.sv
// Directed bench for branch_predictor: BTB training, aliasing, RAS push/pop,
// overflow/underflow, async reset and performance counters.
module tb_branch_predictor;
   import branch_predictor_pkg::*;

   logic        clk;
   logic        rst_n;
   logic [31:0] pc_f;
   logic        pred_taken_f;
   logic [31:0] pc_pred_f;
   logic        upd_valid;
   logic [31:0] upd_pc;
   cflow_mode_t upd_mode;
   logic        upd_taken;
   logic [31:0] upd_target;
   logic        upd_is_call;
   logic        upd_is_ret;
   logic        upd_mispredict;
   logic [31:0] cnt_cflow;
   logic [31:0] cnt_mispredict;

   int checks = 0;
   int errors = 0;

   branch_predictor #(
      .BTB_ENTRIES(64),
      .RAS_DEPTH  (8),
      .CNT_W      (32)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .pc_f          (pc_f),
      .pred_taken_f  (pred_taken_f),
      .pc_pred_f     (pc_pred_f),
      .upd_valid     (upd_valid),
      .upd_pc        (upd_pc),
      .upd_mode      (upd_mode),
      .upd_taken     (upd_taken),
      .upd_target    (upd_target),
      .upd_is_call   (upd_is_call),
      .upd_is_ret    (upd_is_ret),
      .upd_mispredict(upd_mispredict),
      .cnt_cflow     (cnt_cflow),
      .cnt_mispredict(cnt_mispredict)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic look(input string tag, input logic [31:0] pc, input logic exp_t,
                       input logic [31:0] exp_pc);
      pc_f = pc;
      #1;
      chk({tag, "_taken"}, {31'b0, pred_taken_f}, {31'b0, exp_t});
      chk({tag, "_pc"}, pc_pred_f, exp_pc);
   endtask

   task automatic drive(input logic [31:0] pc, input cflow_mode_t mode, input logic taken,
                        input logic [31:0] tgt, input logic call, input logic ret,
                        input logic mis);
      upd_pc         = pc;
      upd_mode       = mode;
      upd_taken      = taken;
      upd_target     = tgt;
      upd_is_call    = call;
      upd_is_ret     = ret;
      upd_mispredict = mis;
      upd_valid      = 1'b1;
   endtask

   task automatic upd(input logic [31:0] pc, input cflow_mode_t mode, input logic taken,
                      input logic [31:0] tgt, input logic call, input logic ret,
                      input logic mis);
      @(negedge clk);
      drive(pc, mode, taken, tgt, call, ret, mis);
      @(posedge clk);
      #1;
      upd_valid = 1'b0;
      $display("upd pc=0x%08h mode=%0d taken=%0b tgt=0x%08h call=%0b ret=%0b mis=%0b",
               pc, mode, taken, tgt, call, ret, mis);
   endtask

   initial begin
      rst_n = 1'b0;
      pc_f  = 32'h0;
      upd_valid = 1'b0;
      drive(32'h0, CFLOW_BRANCH, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
      upd_valid = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;

      // 1: cold lookup after reset
      look("t1_cold", 32'h100, 1'b0, 32'h104);
      chk("t1_cnt_cflow", cnt_cflow, 32'd0);
      chk("t1_cnt_mis", cnt_mispredict, 32'd0);

      // 2: allocate taken branch (ctr=2), then train down to 0
      upd(32'h100, CFLOW_BRANCH, 1'b1, 32'h80, 1'b0, 1'b0, 1'b1);
      look("t2_alloc", 32'h100, 1'b1, 32'h80);
      @(negedge clk);
      drive(32'h100, CFLOW_BRANCH, 1'b0, 32'h80, 1'b0, 1'b0, 1'b0);
      look("t2_preupd", 32'h100, 1'b1, 32'h80);
      @(posedge clk);
      #1;
      upd_valid = 1'b0;
      $display("upd pc=0x00000100 mode=0 taken=0 (same-cycle lookup)");
      look("t2_ctr1", 32'h100, 1'b0, 32'h104);
      upd(32'h100, CFLOW_BRANCH, 1'b0, 32'h80, 1'b0, 1'b0, 1'b0);
      look("t2_ctr0", 32'h100, 1'b0, 32'h104);

      // 3: aliasing on index 0 (ctr 0->1 then replaced)
      upd(32'h100, CFLOW_BRANCH, 1'b1, 32'h80, 1'b0, 1'b0, 1'b0);
      look("t3_alias_miss", 32'h200, 1'b0, 32'h204);
      upd(32'h200, CFLOW_BRANCH, 1'b1, 32'h300, 1'b0, 1'b0, 1'b1);
      look("t3_new_hit", 32'h200, 1'b1, 32'h300);
      look("t3_old_miss", 32'h100, 1'b0, 32'h104);

      // 4: calls reported not-taken so they only touch the RAS, not BTB slot 0
      upd(32'h1000, CFLOW_JAL, 1'b0, 32'h5000, 1'b1, 1'b0, 1'b0);
      upd(32'h2000, CFLOW_JALR, 1'b1, 32'h1004, 1'b0, 1'b1, 1'b0);
      look("t4_ret_empty", 32'h2000, 1'b1, 32'h1004);
      upd(32'h3000, CFLOW_JAL, 1'b0, 32'h5000, 1'b1, 1'b0, 1'b0);
      look("t4_ret_ras", 32'h2000, 1'b1, 32'h3004);

      // 5: overflow with 9 pushes, then drain and underflow
      for (int k = 0; k < 9; k++)
         upd(32'h0C + 32'(k) * 32'h10, CFLOW_JAL, 1'b0, 32'h6000, 1'b1, 1'b0, 1'b0);
      look("t5_top", 32'h2000, 1'b1, 32'h90);
      for (int k = 0; k < 7; k++) begin
         upd(32'h2000, CFLOW_JALR, 1'b1, 32'h1004, 1'b0, 1'b1, 1'b0);
         look($sformatf("t5_pop%0d", k), 32'h2000, 1'b1, 32'h80 - 32'(k) * 32'h10);
      end
      upd(32'h2000, CFLOW_JALR, 1'b1, 32'h1004, 1'b0, 1'b1, 1'b0);
      look("t5_empty", 32'h2000, 1'b1, 32'h1004);
      upd(32'h2000, CFLOW_JALR, 1'b1, 32'h1004, 1'b0, 1'b1, 1'b0);
      look("t5_underflow", 32'h2000, 1'b1, 32'h1004);

      // call+ret: plain push when empty, top replacement otherwise
      upd(32'h4000, CFLOW_JALR, 1'b0, 32'h7000, 1'b1, 1'b1, 1'b0);
      look("t5_cr_empty", 32'h2000, 1'b1, 32'h4004);
      upd(32'h5000, CFLOW_JALR, 1'b0, 32'h7000, 1'b1, 1'b1, 1'b0);
      look("t5_cr_replace", 32'h2000, 1'b1, 32'h5004);
      upd(32'h2000, CFLOW_JALR, 1'b1, 32'h1004, 1'b0, 1'b1, 1'b0);
      look("t5_cr_pop", 32'h2000, 1'b1, 32'h1004);

      chk("t5_cnt_cflow", cnt_cflow, 32'd29);
      chk("t5_cnt_mis", cnt_mispredict, 32'd2);

      // 6: asynchronous reset between edges discards everything
      @(negedge clk);
      #2;
      pc_f  = 32'h2000;
      rst_n = 1'b0;
      #1;
      chk("t6_rst_taken", {31'b0, pred_taken_f}, 32'd0);
      chk("t6_rst_pc", pc_pred_f, 32'h2004);
      chk("t6_rst_cflow", cnt_cflow, 32'd0);
      chk("t6_rst_mis", cnt_mispredict, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      upd(32'h40, CFLOW_BRANCH, 1'b1, 32'h400, 1'b0, 1'b0, 1'b1);
      upd(32'h40, CFLOW_BRANCH, 1'b1, 32'h400, 1'b0, 1'b0, 1'b0);
      upd(32'h44, CFLOW_JAL, 1'b1, 32'h800, 1'b0, 1'b0, 1'b0);
      chk("t6_cnt_cflow", cnt_cflow, 32'd3);
      chk("t6_cnt_mis", cnt_mispredict, 32'd1);
      look("t6_br", 32'h40, 1'b1, 32'h400);
      look("t6_jmp", 32'h44, 1'b1, 32'h800);
      look("t6_old_gone", 32'h2000, 1'b0, 32'h2004);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
